// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and small helpers used by the
// timing generator and downstream renderers.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int CLK_DIV_DEF   = 4;
    localparam int CW_DEF        = 10;

    // Registered decode of the raster position, kept together so it updates atomically.
    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } decode_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int total(input int display, input int front, input int sync, input int back);
        return display + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable generator: one-cycle strobe every CLK_DIV enabled clk cycles.
module pix_ce_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pix_ce
);

    localparam int DW = (clog2(CLK_DIV) > 0) ? clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] count_reg;
    logic          at_last;

    assign at_last = (count_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= at_last ? '0 : count_reg + DW'(1);
        end
    end

    // With CLK_DIV = 1 the counter sits at LAST permanently, so reset must mask the strobe.
    assign pix_ce = enable & at_last & ~reset;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: x/y counters advanced by pix_ce, with sync,
// blanking and line/frame pulses registered from the next-state counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY = H_DISPLAY_DEF,
    parameter int   H_FRONT   = H_FRONT_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BACK    = H_BACK_DEF,
    parameter int   V_DISPLAY = V_DISPLAY_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter int   CLK_DIV   = CLK_DIV_DEF,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          new_line,
    output logic          new_frame,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int XW      = CW + 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Decode bounds carry one extra bit so a boundary equal to 2^CW stays representable.
    localparam logic [CW:0] H_ACT      = XW'(H_DISPLAY);
    localparam logic [CW:0] HS_BEGIN   = XW'(H_DISPLAY + H_FRONT);
    localparam logic [CW:0] HS_END     = XW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW:0] V_ACT      = XW'(V_DISPLAY);
    localparam logic [CW:0] VS_BEGIN   = XW'(V_DISPLAY + V_FRONT);
    localparam logic [CW:0] VS_END     = XW'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [CW-1:0] x_reg, y_reg;
    logic [CW-1:0] x_next, y_next;
    logic [CW:0]   x_ext, y_ext;
    decode_t       decode_reg, decode_next;
    logic          new_line_reg, new_frame_reg;
    logic          line_start, frame_start;
    logic [15:0]   frame_count_reg;

    pix_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .pix_ce (pix_ce)
    );

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (pix_ce) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + CW'(1);
            end else begin
                x_next = x_reg + CW'(1);
            end
        end
    end

    assign line_start  = pix_ce && (x_next == '0);
    assign frame_start = line_start && (y_next == '0);

    assign x_ext = {1'b0, x_next};
    assign y_ext = {1'b0, y_next};

    always_comb begin
        decode_next          = '0;
        decode_next.video_on = (x_ext < H_ACT) && (y_ext < V_ACT);
        decode_next.hsync    = ((x_ext >= HS_BEGIN) && (x_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
        decode_next.vsync    = ((y_ext >= VS_BEGIN) && (y_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg           <= H_LAST;
            y_reg           <= V_LAST;
            decode_reg      <= '{video_on: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};
            new_line_reg    <= 1'b0;
            new_frame_reg   <= 1'b0;
            frame_count_reg <= '0;
        end else if (enable) begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            decode_reg    <= decode_next;
            new_line_reg  <= line_start;
            new_frame_reg <= frame_start;
            if (frame_start) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

    assign x           = x_reg;
    assign y           = y_reg;
    assign video_on    = decode_reg.video_on;
    assign hsync       = decode_reg.hsync;
    assign vsync       = decode_reg.vsync;
    assign frame_count = frame_count_reg;

    // A pulse caught by an enable drop is held and shown once counting resumes.
    assign new_line  = new_line_reg & enable;
    assign new_frame = new_frame_reg & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three timing generators (default, 800x600 positive sync, tiny CLK_DIV=1)
// checked every cycle against an arithmetic raster model driven by enabled-cycle counts.
module tb_vga_timing_gen;

    localparam int NDUT    = 3;
    localparam int N_RESET = 3;
    localparam int N_PH1   = 12003;
    localparam int N_CYC   = 20003;

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb, div;
        bit pol;
    } mode_t;

    typedef struct packed {
        logic        pix_ce;
        logic [15:0] x;
        logic [15:0] y;
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        new_line;
        logic        new_frame;
        logic [15:0] frame_count;
    } obs_t;

    typedef obs_t [NDUT-1:0] trio_t;

    logic clk = 1'b0;
    logic rst_s [NDUT];
    logic en_s  [NDUT];

    logic [NDUT-1:0]       pc, vo, hs, vs, nl, nf;
    logic [NDUT-1:0][15:0] fc;
    logic [9:0]  x0, y0;
    logic [10:0] x1, y1;
    logic [3:0]  x2, y2;

    obs_t [NDUT-1:0] act;
    trio_t exp_q [$];
    mode_t md [NDUT];
    int    ev [NDUT];

    int total_n = 0;
    int bad_n   = 0;
    int mon_cyc = 0;
    int rel0    = 0;
    int first_pc0 = -1;
    int pulse_t [NDUT][2];
    int pulse_n [NDUT];

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .reset(rst_s[0]), .enable(en_s[0]), .pix_ce(pc[0]), .x(x0), .y(y0),
        .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .new_line(nl[0]), .new_frame(nf[0]),
        .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_DISPLAY(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_DISPLAY(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .CLK_DIV(2), .SYNC_POL(1'b1), .CW(11)
    ) u_mode (
        .clk(clk), .reset(rst_s[1]), .enable(en_s[1]), .pix_ce(pc[1]), .x(x1), .y(y1),
        .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .new_line(nl[1]), .new_frame(nf[1]),
        .frame_count(fc[1])
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(1), .SYNC_POL(1'b1), .CW(4)
    ) u_small (
        .clk(clk), .reset(rst_s[2]), .enable(en_s[2]), .pix_ce(pc[2]), .x(x2), .y(y2),
        .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .new_line(nl[2]), .new_frame(nf[2]),
        .frame_count(fc[2])
    );

    always_comb begin
        act = '0;
        for (int d = 0; d < NDUT; d++) begin
            act[d].pix_ce      = pc[d];
            act[d].video_on    = vo[d];
            act[d].hsync       = hs[d];
            act[d].vsync       = vs[d];
            act[d].new_line    = nl[d];
            act[d].new_frame   = nf[d];
            act[d].frame_count = fc[d];
        end
        act[0].x = 16'(x0);
        act[0].y = 16'(y0);
        act[1].x = 16'(x1);
        act[1].y = 16'(y1);
        act[2].x = 16'(x2);
        act[2].y = 16'(y2);
    end

    // Raster position from the number of enabled, out-of-reset clock edges since reset.
    function automatic obs_t model(input mode_t m, input int edges, input bit en, input bit rs);
        obs_t o;
        int ht, vt, tot, n, idx, xi, yi;
        bit last_was_pixel;
        ht  = m.hd + m.hf + m.hs + m.hb;
        vt  = m.vd + m.vf + m.vs + m.vb;
        tot = ht * vt;
        n   = edges / m.div;
        idx = (n + tot - 1) % tot;
        xi  = idx % ht;
        yi  = idx / ht;
        last_was_pixel = (edges > 0) && (edges % m.div == 0);
        o = '0;
        o.pix_ce      = !rs && en && (edges % m.div == m.div - 1);
        o.x           = 16'(xi);
        o.y           = 16'(yi);
        o.video_on    = (xi < m.hd) && (yi < m.vd);
        o.hsync       = (xi >= m.hd + m.hf && xi < m.hd + m.hf + m.hs) ? m.pol : !m.pol;
        o.vsync       = (yi >= m.vd + m.vf && yi < m.vd + m.vf + m.vs) ? m.pol : !m.pol;
        o.new_line    = !rs && en && last_was_pixel && (xi == 0);
        o.new_frame   = o.new_line && (yi == 0);
        o.frame_count = 16'((n + tot - 1) / tot);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%b x=%0d y=%0d vo=%b hs=%b vs=%b nl=%b nf=%b fc=%0d",
                         o.pix_ce, o.x, o.y, o.video_on, o.hsync, o.vsync,
                         o.new_line, o.new_frame, o.frame_count);
    endfunction

    function automatic void check_int(input string name, input int got, input int want);
        total_n++;
        if (got != want) begin
            bad_n++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("check %s: %0d", name, got);
        end
    endfunction

    // Monitor: one scoreboard entry per clk cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        trio_t want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            mon_cyc++;
            for (int d = 0; d < NDUT; d++) begin
                total_n++;
                if (act[d] !== want[d]) begin
                    bad_n++;
                    $display("FAIL sb dut%0d cyc %0d: got %s | expected %s",
                             d, mon_cyc, fmt(act[d]), fmt(want[d]));
                end
            end
            if (!rst_s[0] && first_pc0 < 0) begin
                rel0++;
                if (act[0].pix_ce) first_pc0 = rel0;
            end
            for (int d = 0; d < NDUT; d++) begin
                if (((d == 2) ? act[d].new_frame : act[d].new_line) && pulse_n[d] < 2) begin
                    pulse_t[d][pulse_n[d]] = mon_cyc;
                    pulse_n[d]++;
                end
            end
        end
    end

    initial begin
        trio_t want;
        obs_t  cur;
        int    freeze_left, rst_hold;
        bit    freeze_done, reset_done, async_chk;

        md[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0};
        md[1] = '{800, 40, 128, 88, 600, 1, 4, 23, 2, 1'b1};
        md[2] = '{8, 2, 3, 3, 6, 1, 2, 2, 1, 1'b1};
        freeze_left = 0;
        rst_hold    = 0;
        freeze_done = 0;
        reset_done  = 0;
        for (int d = 0; d < NDUT; d++) begin
            rst_s[d]   = 1'b1;
            en_s[d]    = 1'b1;
            ev[d]      = 0;
            pulse_n[d] = 0;
            pulse_t[d][0] = 0;
            pulse_t[d][1] = 0;
        end

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_s[d] && en_s[d]) ev[d]++;
            end
            #1;
            async_chk = 1'b0;
            if (cyc >= N_RESET) begin
                for (int d = 0; d < NDUT; d++) begin
                    rst_s[d] = 1'b0;
                    en_s[d]  = (cyc < N_PH1) ? 1'b1 : ($urandom_range(7, 0) != 0);
                end
                if (cyc >= N_PH1 && $urandom_range(399, 0) == 0) rst_s[2] = 1'b1;
                cur = model(md[0], ev[0], 1'b1, 1'b0);
                if (!freeze_done && cur.x == 16'd300 && cur.y == 16'd1 && ev[0] % 4 == 0) begin
                    freeze_done = 1'b1;
                    freeze_left = 37;
                    $display("event: dut0 enable low for 37 cycles at x=300 y=1 (cyc %0d)", cyc);
                end
                if (freeze_done && !reset_done && freeze_left == 0 &&
                    cur.x == 16'd123 && cur.y == 16'd2 && ev[0] % 4 == 0) begin
                    reset_done = 1'b1;
                    rst_hold   = 2;
                    async_chk  = 1'b1;
                    $display("event: dut0 async reset at x=123 y=2 (cyc %0d)", cyc);
                end
                if (freeze_left > 0) begin
                    en_s[0] = 1'b0;
                    freeze_left--;
                end
                if (rst_hold > 0) begin
                    rst_s[0] = 1'b1;
                    rst_hold--;
                end
            end
            for (int d = 0; d < NDUT; d++) begin
                if (rst_s[d]) ev[d] = 0;
                want[d] = model(md[d], ev[d], en_s[d], rst_s[d]);
            end
            exp_q.push_back(want);
            if (async_chk) begin
                #1;
                check_int("async_reset_x", int'(x0), 799);
                check_int("async_reset_y", int'(y0), 524);
                check_int("async_reset_hsync", int'(hs[0]), 1);
                check_int("async_reset_vsync", int'(vs[0]), 1);
                check_int("async_reset_frame_count", int'(fc[0]), 0);
            end
        end

        @(negedge clk);
        #1;
        check_int("scoreboard_drained", exp_q.size(), 0);
        check_int("first_pix_ce_cycle", first_pc0, 4);
        check_int("line_period_default",
                  (pulse_n[0] == 2) ? pulse_t[0][1] - pulse_t[0][0] : -1, 3200);
        check_int("line_period_800x600",
                  (pulse_n[1] == 2) ? pulse_t[1][1] - pulse_t[1][0] : -1, 2112);
        check_int("frame_period_small",
                  (pulse_n[2] == 2) ? pulse_t[2][1] - pulse_t[2][0] : -1, 176);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that drives the display pipeline from a single system clock. It derives a pixel-rate clock enable internally rather than a divided clock, and produces registered, mutually aligned x/y coordinates, sync, blanking, line/frame pulses and a frame counter. All timing, sync polarity and divide ratio are parameters, so 640x480@60 and other modes are covered by one block. Pixel renderers and frame-synchronous logic downstream consume `pix_ce`, `x`, `y`, `video_on` and `new_frame`.

## Interface
- `H_DISPLAY`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_DISPLAY`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `CLK_DIV`, 4: `clk` cycles per pixel, ≥1
- `SYNC_POL`, 0: active sync level (0 = active-low)
- `CW`, 10: coordinate width; H_TOTAL and V_TOTAL must both be ≤ 2^CW

- `clk`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  run; low freezes divider, counters and all outputs
- `pix_ce`  out  1  one-`clk` pixel strobe
- `x`  out  CW  current column, 0..H_TOTAL-1
- `y`  out  CW  current line, 0..V_TOTAL-1
- `video_on`  out  1  x < H_DISPLAY and y < V_DISPLAY
- `hsync`  out  1  horizontal sync at SYNC_POL level when active
- `vsync`  out  1  vertical sync at SYNC_POL level when active
- `new_line`  out  1  one-`clk` pulse on entry to x = 0
- `new_frame`  out  1  one-`clk` pulse on entry to (0,0)
- `frame_count`  out  16  frames started since reset, wraps

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider counts 0..CLK_DIV-1 while `enable`. `pix_ce` = 1 in the cycle the divider is at CLK_DIV-1. With CLK_DIV = 1, `pix_ce` = `enable`.
- On a `clk` edge where `pix_ce` = 1: x ← (x = H_TOTAL-1) ? 0 : x+1; y advances only when x wraps, and wraps V_TOTAL-1 → 0.
- Horizontal sync is active for H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC (656..751). Vertical sync is active for V_DISPLAY+V_FRONT ≤ y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- `video_on`, `hsync` and `vsync` are registered. They are decoded from the next-state counters, so they always match the `x`/`y` presented in the same cycle. There is no combinational path from the counters to the outputs.
- `new_line` and `new_frame` are high for exactly the one `clk` cycle after the edge that loads x = 0 or (x,y) = (0,0). `new_frame` implies `new_line`.
- `frame_count` increments on the same edge that loads (0,0); 0xFFFF wraps to 0.
- `enable` low: the divider, counters and all outputs hold, and `pix_ce`, `new_line` and `new_frame` are 0. On re-enable, counting resumes from the held divider value.

## Timing
- Reset state (async, held while `reset` = 1):
  - divider = 0
  - x = H_TOTAL-1, y = V_TOTAL-1
  - `video_on` = 0, `hsync` = `vsync` = inactive (~SYNC_POL)
  - `pix_ce` = `new_line` = `new_frame` = 0
  - `frame_count` = 0
- The reset state is a consistent decode of the last pixel of a frame, so no glitch occurs on release.
- After release with `enable` = 1, the first `pix_ce` is in the CLK_DIV-th cycle. Its edge loads (0,0), sets `video_on` = 1, pulses `new_frame`/`new_line` in the following cycle and sets `frame_count` = 1.
- Latency from the counter edge to all decoded outputs is 0 cycles: they change on the same edge.
- Line period is H_TOTAL·CLK_DIV clk (3200); frame period is H_TOTAL·V_TOTAL·CLK_DIV clk (1,680,000).
- Reset asserted mid-frame returns all outputs to the reset state immediately, without waiting for a clock edge.

## Structure
- Package `vga_pkg` holds the 640x480@60 default timing constants, a `clog2` function and the H_TOTAL/V_TOTAL derivation, shared with the renderers.
- Sub-module `pix_ce_div` (parameter CLK_DIV; ports `clk`, `reset`, `enable`, `pix_ce`) implements the divider. The counters and decode stay in the top module.

## Test plan
- **Reset/first frame.** Defaults, release reset with `enable` = 1. Required: `pix_ce` first in cycle 4; then x=0, y=0, `video_on`=1; `new_frame`=1 for one cycle; `frame_count`=1.
- **Horizontal decode.** Defaults. Required:
  - `hsync` = 0 exactly for x = 656..751.
  - `video_on` falls at x = 640.
  - `new_line` every 3200 clk.
- **Vertical decode and frame wrap.** Defaults, run 2 frames. Required:
  - `vsync` = 0 for y = 490..491.
  - y wraps 524 → 0 at x = 799 → 0.
  - `frame_count` = 2.
  - `new_frame` spacing of 1,680,000 clk.
- **Enable freeze.** Drop `enable` for 37 cycles at x = 300. Required: all outputs constant and `pix_ce` = 0 throughout; x = 301 one divide period after resume.
- **Mode/polarity.** H_DISPLAY=800, H_FRONT=40, H_SYNC=128, H_BACK=88, V_DISPLAY=600, V_FRONT=1, V_SYNC=4, V_BACK=23, CLK_DIV=2, SYNC_POL=1, CW=11. Required:
  - `hsync` = 1 for x = 840..967.
  - `vsync` = 1 for y = 601..604.
  - line = 2112 clk.
- **Mid-frame reset.** Assert `reset` asynchronously at (123,45). Required: x=799, y=524 and syncs inactive before the next clk edge; `frame_count` = 0.
